// File: rtl/uart_ctrl_pkg.sv
// Shared constants and state encoding for the UART transmit arbiter.
package uart_ctrl_pkg;

  localparam int unsigned DATA_W          = 8;
  localparam int unsigned DEFAULT_TIMEOUT = 60000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StStart = ST_START,
    StWait  = ST_WAIT
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_i, wrapping around.
module rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] last_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    // Scan farthest first so the nearest hit after last_i overwrites the rest.
    for (int off = int'(N); off >= 1; off--) begin
      cand = IdxW'((int'(last_i) + off) % int'(N));
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ clients, with a tx_end watchdog.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic                      busy,
  output logic                      tx_req,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_end
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [NUM_REQ-1:0]  err_q, err_d;
  logic                tx_req_q, tx_req_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [IdxW-1:0]     idx_q, idx_d;

  logic                pick_valid;
  logic [IdxW-1:0]     pick_idx;

  rr_pick #(
    .N    (NUM_REQ),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req_i   (req),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    err_d     = '0;
    tx_req_d  = 1'b0;
    tx_data_d = tx_data_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    idx_d     = idx_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d   = StStart;
          idx_d     = pick_idx;
          gnt_d     = NUM_REQ'(1) << pick_idx;
          tx_data_d = req_data[DATA_W*int'(pick_idx) +: DATA_W];
          tx_req_d  = 1'b1;
          cnt_d     = '0;
        end
      end
      StStart: begin
        // Counting starts with the tx_req cycle so the abort lands TIMEOUT cycles after it.
        state_d = StWait;
        cnt_d   = cnt_q + CntW'(1);
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (tx_end) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          last_d  = idx_q;
          state_d = StIdle;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          err_d   = gnt_q;
          gnt_d   = '0;
          last_d  = idx_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      tx_req_q  <= 1'b0;
      tx_data_q <= '0;
      cnt_q     <= '0;
      last_q    <= IdxW'(NUM_REQ - 1);
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      tx_req_q  <= tx_req_d;
      tx_data_q <= tx_data_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign err     = err_q;
  assign tx_req  = tx_req_q;
  assign tx_data = tx_data_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares the single UART transmitter (tx_req / tx_data / tx_end handshake of the rs232 uart core) between NUM_REQ client blocks.
- Latches one byte per grant, issues a one-cycle tx_req, waits for tx_end, then reports completion to the granted client.
- A watchdog aborts a transfer if tx_end never arrives.
- Sits between application logic and the uart instance at top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 60000, clk cycles to wait for tx_end before aborting (covers one 11-bit frame at 9600 baud, 50 MHz, with margin).

Ports:
- clk  in  1  main clock
- rst  in  1  main reset, synchronous, active-high
- req  in  NUM_REQ  level request per client; client holds its byte on req_data while req is high
- req_data  in  NUM_REQ*8  byte of client i on bits [8i+7:8i]
- gnt  out  NUM_REQ  one-hot; marks the client owning the transmitter for the current transfer
- done  out  NUM_REQ  one-cycle pulse to the granted client when its byte has been sent
- err  out  NUM_REQ  one-cycle pulse to the granted client on watchdog abort
- busy  out  1  high whenever state is not IDLE
- tx_req  out  1  one-cycle send request to the uart
- tx_data  out  8  byte to the uart; stable from tx_req until the transfer ends
- tx_end  in  1  one-cycle pulse from the uart when the frame is complete

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high. All state is updated on posedge clk only.
- Reset values:
  - state=IDLE
  - gnt=0, done=0, err=0, tx_req=0, tx_data=8'h00, busy=0
  - watchdog count=0
  - last=NUM_REQ-1, so client 0 has first priority.
  - rst asserted mid-transfer: abort immediately; no done or err pulse is issued. A uart frame already in flight is not cancelled.
- States: IDLE, START, WAIT.
- IDLE:
  - If req is nonzero, select the winner idx as the first set bit searching last+1 .. NUM_REQ-1, then 0 .. last.
  - Next cycle: gnt=onehot(idx), tx_data=req_data[idx], count=0, state=START.
  - If req is zero, remain in IDLE.
- START:
  - tx_req=1 for exactly this one cycle; then state=WAIT.
  - tx_end is ignored in START.
- WAIT:
  - count increments each cycle.
  - On tx_end: next cycle done[idx]=1, gnt=0, last=idx, state=IDLE.
  - Else if count==TIMEOUT-1: next cycle err[idx]=1, gnt=0, last=idx, state=IDLE.
  - If tx_end and the timeout occur in the same cycle, tx_end wins: done is pulsed, err is not.
- Latency:
  - req rising in IDLE at cycle k: gnt and tx_data valid at k+1; tx_req high at k+1.
  - tx_end at cycle m: done at m+1.
  - The earliest next grant is at m+2, because IDLE re-arbitrates on the cycle done is high.
- Data and request rules:
  - tx_data is latched once at grant; later changes on req_data or req are ignored.
  - A client dropping req mid-transfer does not cancel the transfer; done or err is still pulsed.
  - A client holding req continuously receives a new grant only after every other pending client has been served once.
- Counter: width $clog2(TIMEOUT+1). The counter is not used outside WAIT.
- tx_end outside WAIT has no effect.

Decomposition:
- Package uart_ctrl_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_START=2'd1, ST_WAIT=2'd2.
  - DATA_W=8.
  - default TIMEOUT constant.
- Sub-module rr_pick (combinational):
  - inputs: req vector and last index.
  - outputs: valid flag and winner index.
  - reused by future shared-resource arbiters.
- All registers reside in uart_tx_arbiter.

Test Plan:
1. Reset then single request: req=4'b0010, req_data[15:8]=8'hA5.
   - Required: gnt=4'b0010, tx_data=8'hA5 and tx_req pulse one cycle later.
   - With a uart model pulsing tx_end 20 cycles later: done=4'b0010 one cycle after tx_end; busy falls.
2. All four clients requesting continuously (bytes 8'h10, 8'h11, 8'h12, 8'h13).
   - Required: grant order 0,1,2,3,0; tx_data sequence 8'h10, 8'h11, 8'h12, 8'h13, 8'h10; exactly one done per transfer.
3. Watchdog with TIMEOUT=16 and no tx_end.
   - Required: err[idx] pulses exactly 16 cycles after tx_req; done stays 0; the next pending client is granted two cycles later.
4. tx_end arriving on the cycle count==TIMEOUT-1.
   - Required: done pulses; err remains 0.
5. Client changes req_data and drops req one cycle after grant.
   - Required: tx_data holds the originally latched byte; done is still pulsed to that client.
6. rst asserted during WAIT.
   - Required: next cycle all outputs are 0 and state is IDLE with no done or err pulse; a subsequent request from client 3 alongside client 0 grants client 0 first.
